// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, immediate extension and forwarding selects,
// plus the ID/EX latch record used by ex_operand_stage.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_LUI  = 2'd2
    } ext_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        regbits_t rs;
        regbits_t rt;
        regbits_t rd;
        word_t    rsData;
        word_t    rtData;
        word_t    imm;
        logic     alusrc;
        regbits_t aluop;
        logic     regwrite;
        logic     memread;
    } id_ex_t;

    // Unused encoding 3 falls back to zero extension.
    function automatic word_t extendImm(input logic [15:0] imm, input logic [1:0] ext);
        word_t result;
        case (ext)
            EXT_SIGN: result = {{16{imm[15]}}, imm};
            EXT_LUI:  result = {imm, 16'h0000};
            default:  result = {16'h0000, imm};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding for one source register: EX/MEM beats MEM/WB,
// register 0 is never forwarded.
module forward_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] srcAddr_i,
    input  logic [DATA_W-1:0]  regData_i,
    input  logic               exmemRegwrite_i,
    input  logic [RADDR_W-1:0] exmemRd_i,
    input  logic [DATA_W-1:0]  exmemResult_i,
    input  logic               memwbRegwrite_i,
    input  logic [RADDR_W-1:0] memwbRd_i,
    input  logic [DATA_W-1:0]  memwbResult_i,
    output fwd_sel_t           fwdSel_o,
    output logic [DATA_W-1:0]  fwdData_o
);

    always_comb begin
        fwdSel_o  = FWD_NONE;
        fwdData_o = regData_i;
        if (srcAddr_i != '0) begin
            if (exmemRegwrite_i && (exmemRd_i == srcAddr_i)) begin
                fwdSel_o  = FWD_EXMEM;
                fwdData_o = exmemResult_i;
            end else if (memwbRegwrite_i && (memwbRd_i == srcAddr_i)) begin
                fwdSel_o  = FWD_MEMWB;
                fwdData_o = memwbResult_i;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage feeding the ALU: valid/ready latch, immediate extension, forwarding.
// Define LOAD_USE_STALL_EN to add load-use hazard detection and the stall_o output.
module ex_operand_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [RADDR_W-1:0] dec_rs_addr,
    input  logic [RADDR_W-1:0] dec_rt_addr,
    input  logic [RADDR_W-1:0] dec_rd_addr,
    input  logic [DATA_W-1:0]  dec_rs_data,
    input  logic [DATA_W-1:0]  dec_rt_data,
    input  logic [15:0]        dec_imm,
    input  logic [1:0]         dec_ext,
    input  logic               dec_alusrc,
    input  logic [RADDR_W-1:0] dec_aluop,
    input  logic               dec_regwrite,
    input  logic               dec_memread,
    input  logic               exmem_regwrite,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_regwrite,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_result,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  PortA,
    output logic [DATA_W-1:0]  PortB,
    output logic [RADDR_W-1:0] ALUOP,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic [DATA_W-1:0]  ex_store_data
`ifdef LOAD_USE_STALL_EN
    ,
    output logic               stall_o
`endif
);

    id_ex_t ex_q, ex_d;
    logic   exValid_q, exValid_d;
    logic   loadUseStall;
    logic   capture;

    fwd_sel_t          fwdSelA, fwdSelB;
    logic [DATA_W-1:0] fwdDataA, fwdDataB;
    logic              unusedFwdSel;

`ifdef LOAD_USE_STALL_EN
    // rt only matters when it is actually read as the second ALU operand.
    assign loadUseStall = exValid_q && ex_q.memread && (ex_q.rd != '0) &&
                          ((ex_q.rd == dec_rs_addr) || ((ex_q.rd == dec_rt_addr) && !dec_alusrc));
    assign stall_o      = loadUseStall;
`else
    assign loadUseStall = 1'b0;
`endif

    assign dec_ready = (!exValid_q || ex_ready) && !loadUseStall;
    assign capture   = dec_valid && dec_ready && !flush;

    always_comb begin
        exValid_d = exValid_q;
        ex_d      = ex_q;
        if (flush) begin
            exValid_d = 1'b0;
        end else if (capture) begin
            exValid_d   = 1'b1;
            ex_d.rs       = dec_rs_addr;
            ex_d.rt       = dec_rt_addr;
            ex_d.rd       = dec_rd_addr;
            ex_d.rsData   = dec_rs_data;
            ex_d.rtData   = dec_rt_data;
            ex_d.imm      = extendImm(dec_imm, dec_ext);
            ex_d.alusrc   = dec_alusrc;
            ex_d.aluop    = dec_aluop;
            ex_d.regwrite = dec_regwrite;
            ex_d.memread  = dec_memread;
        end else if (ex_ready) begin
            exValid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            exValid_q <= 1'b0;
            ex_q      <= '0;
        end else begin
            exValid_q <= exValid_d;
            ex_q      <= ex_d;
        end
    end

    forward_unit #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs (
        .srcAddr_i       (ex_q.rs),
        .regData_i       (ex_q.rsData),
        .exmemRegwrite_i (exmem_regwrite),
        .exmemRd_i       (exmem_rd),
        .exmemResult_i   (exmem_result),
        .memwbRegwrite_i (memwb_regwrite),
        .memwbRd_i       (memwb_rd),
        .memwbResult_i   (memwb_result),
        .fwdSel_o        (fwdSelA),
        .fwdData_o       (fwdDataA)
    );

    forward_unit #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rt (
        .srcAddr_i       (ex_q.rt),
        .regData_i       (ex_q.rtData),
        .exmemRegwrite_i (exmem_regwrite),
        .exmemRd_i       (exmem_rd),
        .exmemResult_i   (exmem_result),
        .memwbRegwrite_i (memwb_regwrite),
        .memwbRd_i       (memwb_rd),
        .memwbResult_i   (memwb_result),
        .fwdSel_o        (fwdSelB),
        .fwdData_o       (fwdDataB)
    );

    // Select codes are only observed in simulation.
    assign unusedFwdSel = ^{fwdSelA, fwdSelB};

    assign ex_valid      = exValid_q;
    assign PortA         = fwdDataA;
    assign PortB         = ex_q.alusrc ? ex_q.imm : fwdDataB;
    assign ALUOP         = ex_q.aluop;
    assign ex_store_data = fwdDataB;
    assign ex_rd         = exValid_q ? ex_q.rd : '0;
    assign ex_regwrite   = exValid_q && ex_q.regwrite;
    assign ex_memread    = exValid_q && ex_q.memread;

endmodule
